log2_iter: RTL and testbench

LOG2_ITER -- requirements
Module: log2_iter

---
 rtl/log2_pkg.sv | 16 +
 rtl/log2_iter_lod.sv | 15 +
 rtl/log2_iter.sv | 112 +++++++++++
 tb/tb_log2_iter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/log2_pkg.sv
// log2_pkg: shared constants and FSM state type for the iterative log2 unit.
// LOG2_ROUND_EN adds a seventh iteration used for round-to-nearest.
package log2_pkg;
    localparam int DIN_W  = 16;
    localparam int FRAC_W = 6;
    localparam int MANT_W = 16;
    localparam int POS_W  = 4;
    localparam int DOUT_W = POS_W + FRAC_W;
    localparam int CNT_W  = 3;
`ifdef LOG2_ROUND_EN
    localparam int ITERS = FRAC_W + 1;
`else
    localparam int ITERS = FRAC_W;
`endif
    typedef enum logic [1:0] {IDLE, NORM, FRAC, DONE} state_e;
endpackage

// File: rtl/log2_iter_lod.sv
// lead_one_det: combinational leading-one position and zero flag of a 16-bit word.
module lead_one_det
    import log2_pkg::*;
(
    input  logic [DIN_W-1:0] val_i,
    output logic [POS_W-1:0] pos_o,
    output logic             zero_o
);
    always_comb begin
        pos_o = '0;
        for (int i = 0; i < DIN_W; i++)
            if (val_i[i]) pos_o = POS_W'(i);
        zero_o = ~|val_i;
    end
endmodule

// File: rtl/log2_iter.sv
// log2_iter: iterative log2 of an unsigned integer, one fraction bit per cycle by squaring.
// Define LOG2_ROUND_EN for a rounded, saturated result (one extra cycle).
module log2_iter #(
    parameter int DIN_W  = 16,
    parameter int FRAC_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [FRAC_W+3:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              zero_err
);
    import log2_pkg::*;

    state_e              state_q;
    logic [MANT_W-1:0]   din_q, m_q, m_d, m_norm;
    logic [POS_W-1:0]    pos_q, pos;
    logic                zero;
    logic [ITERS-1:0]    frac_q, frac_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [DOUT_W-1:0]   dout_q, res_d;
    logic                dout_valid_q, zero_err_q, din_ready_q;
    logic [2*MANT_W-1:0] sq;
    logic                unused_bits;
`ifdef LOG2_ROUND_EN
    logic [DOUT_W+1:0]   rnd;
`endif

    lead_one_det u_lod (
        .val_i  (din_q),
        .pos_o  (pos),
        .zero_o (zero)
    );

    // Squaring a Q1.15 mantissa gives Q2.30; a set MSB means m^2 >= 2, i.e. fraction bit 1.
    always_comb begin
        m_norm = din_q << (4'd15 - pos);
        sq     = {{MANT_W{1'b0}}, m_q} * {{MANT_W{1'b0}}, m_q};
        m_d    = sq[31] ? sq[31:16] : sq[30:15];
        frac_d = {frac_q[ITERS-2:0], sq[31]};
`ifdef LOG2_ROUND_EN
        rnd         = {1'b0, pos_q, frac_d} + 12'd1;
        res_d       = rnd[DOUT_W+1] ? '1 : rnd[DOUT_W:1];
        unused_bits = ^{sq[14:0], rnd[0]};
`else
        res_d       = {pos_q, frac_d};
        unused_bits = ^sq[14:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            din_q        <= '0;
            pos_q        <= '0;
            m_q          <= '0;
            frac_q       <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            zero_err_q   <= 1'b0;
            din_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (din_valid) begin
                    din_q       <= din;
                    din_ready_q <= 1'b0;
                    state_q     <= NORM;
                end
                NORM: if (zero) begin
                    dout_q     <= '0;
                    zero_err_q <= 1'b1;
                    state_q    <= DONE;
                end else begin
                    pos_q   <= pos;
                    m_q     <= m_norm;
                    frac_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= FRAC;
                end
                FRAC: begin
                    m_q    <= m_d;
                    frac_q <= frac_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        dout_q     <= res_d;
                        zero_err_q <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                // First DONE cycle publishes the result; the handshake is seen from then on.
                DONE: if (!dout_valid_q) begin
                    dout_valid_q <= 1'b1;
                end else if (dout_ready) begin
                    dout_valid_q <= 1'b0;
                    din_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign zero_err   = zero_err_q;
endmodule

// File: tb/tb_log2_iter.sv
// tb_log2_iter: self-checking bench for log2_iter against a squaring-rule reference model.
module tb_log2_iter;
`ifdef LOG2_ROUND_EN
    localparam int ITERS = 7;
    localparam int LAT   = 9;
`else
    localparam int ITERS = 6;
    localparam int LAT   = 8;
`endif

    logic        clk = 0;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [9:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        zero_err;
    int          checks = 0;
    int          errors = 0;

    log2_iter #(.DIN_W(16), .FRAC_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .zero_err   (zero_err)
    );

    always #5 clk = ~clk;

    // Integer part is the leading-one index; each squaring of the mantissa yields one fraction bit.
    function automatic int ref_log2(input int x);
        int p, r;
        longint unsigned m, sq;
        if (x == 0) return 0;
        p = 0;
        while ((x >> (p + 1)) != 0) p++;
        m = 64'(x) << (15 - p);
        r = p;
        for (int i = 0; i < ITERS; i++) begin
            sq = m * m;
            if (sq >= 64'h8000_0000) begin
                r = r * 2 + 1;
                m = sq >> 16;
            end else begin
                r = r * 2;
                m = sq >> 15;
            end
        end
`ifdef LOG2_ROUND_EN
        r = (r + 1) / 2;
        if (r > 1023) r = 1023;
`endif
        return r;
    endfunction

    task automatic do_op(input logic [15:0] x, output logic [9:0] r, output logic z, output int lat);
        int guard = 0;
        while (!din_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        din = x;
        din_valid = 1;
        @(posedge clk); #1;
        din_valid = 0;
        lat = 0;
        while (!dout_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        r = dout;
        z = zero_err;
    endtask

    task automatic consume();
        dout_ready = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
        checks++; if (dout !== 10'h000) begin errors++; $display("FAIL reset_dout: got %h expected 000", dout); end
        checks++; if (zero_err !== 1'b0) begin errors++; $display("FAIL reset_zero_err: got %b expected 0", zero_err); end
        rst = 0;
        @(posedge clk); #1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b expected 1", din_ready); end
    endtask

    task automatic test_vectors();
        logic [15:0] vin  [8] = '{16'd2, 16'd0, 16'd1, 16'd3, 16'hFFFF, 16'd4, 16'h8000, 16'h0400};
        logic [9:0]  vexp [8] = '{10'h040, 10'h000, 10'h000, 10'h065, 10'h3FF, 10'h080, 10'h3C0, 10'h280};
        logic [9:0] r;
        logic z;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(vin[i], r, z, lat);
            checks++; if (r !== vexp[i]) begin errors++; $display("FAIL vec_dout din=%h: got %h expected %h", vin[i], r, vexp[i]); end
            checks++; if (z !== (vin[i] == 0)) begin errors++; $display("FAIL vec_zero_err din=%h: got %b expected %b", vin[i], z, vin[i] == 0); end
            checks++; if (lat != ((vin[i] == 0) ? 2 : LAT)) begin errors++; $display("FAIL vec_latency din=%h: got %0d expected %0d", vin[i], lat, (vin[i] == 0) ? 2 : LAT); end
            consume();
            checks++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL vec_release din=%h: got valid=%b ready=%b expected valid=0 ready=1", vin[i], dout_valid, din_ready); end
        end
    endtask

    task automatic test_stall();
        logic [9:0] r;
        logic z;
        int lat;
        dout_ready = 0;
        do_op(16'd3, r, z, lat);
        for (int i = 0; i < 5; i++) begin
            checks++; if (dout !== 10'h065 || dout_valid !== 1'b1) begin errors++; $display("FAIL stall_hold cycle %0d: got dout=%h valid=%b expected dout=065 valid=1", i, dout, dout_valid); end
            checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL stall_din_ready cycle %0d: got %b expected 0", i, din_ready); end
            din = 16'h1234;
            din_valid = i[0];
            @(posedge clk); #1;
        end
        din_valid = 0;
        consume();
        checks++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got valid=%b ready=%b expected valid=0 ready=1", dout_valid, din_ready); end
        checks++; if (dout !== 10'h065) begin errors++; $display("FAIL stall_idle_hold: got %h expected 065", dout); end
        do_op(16'd2, r, z, lat);
        checks++; if (r !== 10'h040 || lat != LAT) begin errors++; $display("FAIL stall_next_op: got %h lat %0d expected 040 lat %0d", r, lat, LAT); end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [9:0] r;
        logic z;
        int lat;
        bit seen = 0;
        din = 16'hABCD;
        din_valid = 1;
        @(posedge clk); #1;
        din_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        #2;
        checks++; if (dout_valid !== 1'b0 || dout !== 10'h000 || zero_err !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL midreset_outputs: got valid=%b dout=%h zerr=%b ready=%b expected 0 000 0 1", dout_valid, dout, zero_err, din_ready); end
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (dout_valid) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midreset_no_result: got dout_valid=1 expected 0"); end
        do_op(16'd4, r, z, lat);
        checks++; if (r !== 10'h080 || z !== 1'b0 || lat != LAT) begin errors++; $display("FAIL midreset_next_op: got %h zerr %b lat %0d expected 080 0 %0d", r, z, lat, LAT); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [9:0] r;
        logic z;
        int lat, x, e, fl;
        real lg;
        for (int n = 0; n < 2000; n++) begin
            x = (n % 4 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 65535);
            e = ref_log2(x);
            do_op(16'(x), r, z, lat);
            checks++; if (int'(r) != e) begin errors++; $display("FAIL rand_dout din=%h: got %h expected %h", x, r, e); end
            checks++; if (z !== (x == 0)) begin errors++; $display("FAIL rand_zero_err din=%h: got %b expected %b", x, z, x == 0); end
            checks++; if (lat != ((x == 0) ? 2 : LAT)) begin errors++; $display("FAIL rand_latency din=%h: got %0d expected %0d", x, lat, (x == 0) ? 2 : LAT); end
            if (x > 0) begin
                lg = $ln(real'(x)) / $ln(2.0) * 64.0;
                fl = int'($floor(lg));
                checks++; if (int'(r) < fl - 1 || int'(r) > fl + 1) begin errors++; $display("FAIL rand_accuracy din=%h: got %0d expected %0d +/-1", x, r, fl); end
            end
            consume();
        end
    endtask

    initial begin
        rst = 1;
        din = 0;
        din_valid = 0;
        dout_ready = 1;
        test_reset();
        test_vectors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
